// File: rtl/mips_pkg.sv
// Shared state, opcode and control-field encodings for the multicycle MIPS control unit.
package mips_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUB_REG   = 2'd0;
    localparam logic [1:0] ALUB_FOUR  = 2'd1;
    localparam logic [1:0] ALUB_IMM   = 2'd2;
    localparam logic [1:0] ALUB_IMMSH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    typedef struct packed {
        logic       regDst;
        logic       aluSrcA;
        logic       memToReg;
        logic       iord;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
        logic       irWrite;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic isSupported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Pure state-to-control-word decoder; unknown state encodings decode to an all-zero word.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    output logic [CTRL_W-1:0]  o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.memRead = 1'b1;
                w_ctrl.iord    = 1'b0;
                w_ctrl.irWrite = 1'b1;
                w_ctrl.aluSrcA = 1'b0;
                w_ctrl.aluSrcB = ALUB_FOUR;
                w_ctrl.aluOp   = ALUOP_ADD;
                w_ctrl.pcSrc   = PCSRC_ALU;
                w_ctrl.pcWrite = 1'b1;
            end
            S_DECODE: begin
                w_ctrl.aluSrcA = 1'b0;
                w_ctrl.aluSrcB = ALUB_IMMSH;
                w_ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = ALUB_IMM;
                w_ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctrl.memRead = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.regDst   = 1'b0;
                w_ctrl.memToReg = 1'b1;
                w_ctrl.regWrite = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.memWrite = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = ALUB_REG;
                w_ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                w_ctrl.regDst   = 1'b1;
                w_ctrl.memToReg = 1'b0;
                w_ctrl.regWrite = 1'b1;
            end
            // Final PC enable (pc_write | pc_write_cond & zero) is formed in the datapath.
            S_BRANCH: begin
                w_ctrl.aluSrcA     = 1'b1;
                w_ctrl.aluSrcB     = ALUB_REG;
                w_ctrl.aluOp       = ALUOP_SUB;
                w_ctrl.pcSrc       = PCSRC_ALUOUT;
                w_ctrl.pcWriteCond = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pcSrc   = PCSRC_JUMP;
                w_ctrl.pcWrite = 1'b1;
            end
            S_ADDIEX: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = ALUB_IMM;
                w_ctrl.aluOp   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                w_ctrl.regDst   = 1'b0;
                w_ctrl.memToReg = 1'b0;
                w_ctrl.regWrite = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and output gating.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic             mem_to_reg,
    output logic             iord,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             bad_op,
    output logic [3:0]       state
);

    state_t              r_state;
    state_t              w_nextState;
    logic                r_badOp;
    logic                w_badOpNext;
    logic [CTRL_W-1:0]   w_decBits;
    ctrl_t               w_decCtrl;
    ctrl_t               w_ctrl;
    logic                w_unusedZero;

    // The zero flag is consumed by the datapath's PC-enable gate, not here.
    assign w_unusedZero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_badOp <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_badOp <= w_badOpNext;
        end
    end

    always_comb begin
        w_nextState = S_FETCH;
        w_badOpNext = 1'b0;
        case (r_state)
            S_FETCH:  w_nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: w_nextState = S_EXEC;
                    OP_LW,
                    OP_SW:    w_nextState = S_MEMADR;
                    OP_BEQ:   w_nextState = S_BRANCH;
                    OP_J:     w_nextState = S_JUMP;
                    OP_ADDI:  w_nextState = S_ADDIEX;
                    default:  w_nextState = S_FETCH;
                endcase
                w_badOpNext = !isSupported(opcode);
            end
            S_MEMADR: begin
                if (opcode == OP_LW)
                    w_nextState = S_MEMRD;
                else if (opcode == OP_SW)
                    w_nextState = S_MEMWR;
                else
                    w_nextState = S_FETCH;
            end
            S_MEMRD:  w_nextState = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_nextState = S_FETCH;
            S_MEMWR:  w_nextState = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_nextState = S_RWB;
            S_RWB:    w_nextState = S_FETCH;
            S_BRANCH: w_nextState = S_FETCH;
            S_JUMP:   w_nextState = S_FETCH;
            S_ADDIEX: w_nextState = S_ADDIWB;
            S_ADDIWB: w_nextState = S_FETCH;
            default:  w_nextState = S_FETCH;
        endcase
    end

    mips_mc_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_decBits)
    );

    assign w_decCtrl = ctrl_t'(w_decBits);

    // IR and PC only latch once the fetch completes; reset forces a quiet control word.
    always_comb begin
        w_ctrl = w_decCtrl;
        if (r_state == S_FETCH && !mem_ready) begin
            w_ctrl.irWrite = 1'b0;
            w_ctrl.pcWrite = 1'b0;
        end
        if (reset)
            w_ctrl = '0;
    end

    assign reg_dst       = w_ctrl.regDst;
    assign alu_src_a     = w_ctrl.aluSrcA;
    assign mem_to_reg    = w_ctrl.memToReg;
    assign iord          = w_ctrl.iord;
    assign alu_src_b     = w_ctrl.aluSrcB;
    assign pc_src        = w_ctrl.pcSrc;
    assign alu_op        = w_ctrl.aluOp;
    assign ir_write      = w_ctrl.irWrite;
    assign pc_write      = w_ctrl.pcWrite;
    assign pc_write_cond = w_ctrl.pcWriteCond;
    assign mem_read      = w_ctrl.memRead;
    assign mem_write     = w_ctrl.memWrite;
    assign reg_write     = w_ctrl.regWrite;
    assign bad_op        = r_badOp;
    assign state         = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through its state sequence.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;
    logic       reg_dst, alu_src_a, mem_to_reg, iord;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write;
    logic       bad_op;
    logic [3:0] state;
    logic [15:0] ctrlBits;

    int nChecks = 0;
    int nPassed = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.OPC_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (memReady),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .mem_to_reg    (mem_to_reg),
        .iord          (iord),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .bad_op        (bad_op),
        .state         (state)
    );

    assign ctrlBits = {reg_dst, alu_src_a, mem_to_reg, iord, alu_src_b, pc_src, alu_op,
                       ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write};

    // Expected control word per state, in the same field order as ctrlBits.
    function automatic logic [15:0] expCtrl(input int st, input logic rdy);
        logic       rd, sa, m2r, io, irw, pcw, pcc, mr, mw, rw;
        logic [1:0] sb, ps, op;
        {rd, sa, m2r, io, irw, pcw, pcc, mr, mw, rw} = '0;
        {sb, ps, op} = '0;
        case (st)
            0:  begin mr = 1; irw = rdy; pcw = rdy; sb = 2'd1; end
            1:  begin sb = 2'd3; end
            2:  begin sa = 1; sb = 2'd2; end
            3:  begin mr = 1; io = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin sa = 1; op = 2'd2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; op = 2'd1; ps = 2'd1; pcc = 1; end
            9:  begin ps = 2'd2; pcw = 1; end
            10: begin sa = 1; sb = 2'd2; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {rd, sa, m2r, io, sb, ps, op, irw, pcw, pcc, mr, mw, rw};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            nPassed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive mem_ready, check the current state's outputs, then advance one clock.
    task automatic applyStimulus(input string tag, input int expSt, input logic rdy);
        memReady = rdy;
        #1;
        checkOutput($sformatf("%s/state", tag), {28'd0, state}, expSt);
        checkOutput($sformatf("%s/ctrl", tag), {16'd0, ctrlBits}, {16'd0, expCtrl(expSt, rdy)});
        checkOutput($sformatf("%s/badop", tag), {31'd0, bad_op}, 32'd0);
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 6'b100011;
        zero     = 1'b0;
        memReady = 1'b1;
        tick();
        tick();
        #1;
        checkOutput("rst/state", {28'd0, state}, 32'd0);
        checkOutput("rst/ctrl", {16'd0, ctrlBits}, 32'd0);
        checkOutput("rst/badop", {31'd0, bad_op}, 32'd0);
        reset = 1'b0;

        // LW, no wait states
        applyStimulus("lw", 0, 1'b1);
        applyStimulus("lw", 1, 1'b1);
        applyStimulus("lw", 2, 1'b1);
        applyStimulus("lw", 3, 1'b1);
        applyStimulus("lw", 4, 1'b1);

        // SW with three stall cycles; mem_ready low in DECODE/MEMADR must be ignored
        opcode = 6'b101011;
        applyStimulus("sw", 0, 1'b1);
        applyStimulus("sw", 1, 1'b0);
        applyStimulus("sw", 2, 1'b0);
        applyStimulus("sw", 5, 1'b0);
        applyStimulus("sw", 5, 1'b0);
        applyStimulus("sw", 5, 1'b0);
        applyStimulus("sw", 5, 1'b1);

        // BEQ with one fetch wait
        opcode = 6'b000100;
        zero   = 1'b1;
        applyStimulus("beq", 0, 1'b0);
        applyStimulus("beq", 0, 1'b1);
        applyStimulus("beq", 1, 1'b1);
        applyStimulus("beq", 8, 1'b1);
        zero = 1'b0;

        // R-type then J back to back
        opcode = 6'b000000;
        applyStimulus("r", 0, 1'b1);
        applyStimulus("r", 1, 1'b1);
        applyStimulus("r", 6, 1'b1);
        applyStimulus("r", 7, 1'b1);
        opcode = 6'b000010;
        applyStimulus("j", 0, 1'b1);
        applyStimulus("j", 1, 1'b1);
        applyStimulus("j", 9, 1'b1);

        // ADDI
        opcode = 6'b001000;
        applyStimulus("addi", 0, 1'b1);
        applyStimulus("addi", 1, 1'b1);
        applyStimulus("addi", 10, 1'b1);
        applyStimulus("addi", 11, 1'b1);

        // Unsupported opcode: one-cycle bad_op pulse, back in FETCH
        opcode = 6'b111111;
        applyStimulus("bad", 0, 1'b1);
        applyStimulus("bad", 1, 1'b1);
        memReady = 1'b0;
        #1;
        checkOutput("bad/pulseState", {28'd0, state}, 32'd0);
        checkOutput("bad/pulse", {31'd0, bad_op}, 32'd1);
        checkOutput("bad/pulseCtrl", {16'd0, ctrlBits}, {16'd0, expCtrl(0, 1'b0)});
        tick();
        #1;
        checkOutput("bad/pulseEnd", {31'd0, bad_op}, 32'd0);
        checkOutput("bad/holdFetch", {28'd0, state}, 32'd0);

        // Reset while stalled in MEMRD
        opcode = 6'b100011;
        applyStimulus("rstmem", 0, 1'b1);
        applyStimulus("rstmem", 1, 1'b1);
        applyStimulus("rstmem", 2, 1'b0);
        applyStimulus("rstmem", 3, 1'b0);
        memReady = 1'b0;
        #1;
        checkOutput("rstmem/stalled", {28'd0, state}, 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("rstmem/ctrlHeld", {16'd0, ctrlBits}, 32'd0);
        tick();
        #1;
        checkOutput("rstmem/state", {28'd0, state}, 32'd0);
        checkOutput("rstmem/memRead", {31'd0, mem_read}, 32'd0);
        checkOutput("rstmem/regWrite", {31'd0, reg_write}, 32'd0);
        tick();
        #1;
        checkOutput("rstmem/ctrl", {16'd0, ctrlBits}, 32'd0);
        reset = 1'b0;
        applyStimulus("post", 0, 1'b1);
        applyStimulus("post", 1, 1'b1);
        applyStimulus("post", 2, 1'b1);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
